// File: rtl/fb_pkg.sv
// fb_pkg: shared frame-buffer geometry, coordinate widths, arbiter state
// encoding and the pixel record used on the RAM write path.
package fb_pkg;

    localparam int FB_W_DEF    = 160;
    localparam int FB_H_DEF    = 120;
    localparam int X_W         = 8;
    localparam int Y_W         = 7;
    // Widest colour word the pixel record can carry (8 bits per channel).
    localparam int COLOR_W_MAX = 24;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
        logic [COLOR_W_MAX-1:0] color;
    } pixel_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// fb_write_arbiter_if: bundle of the clear-control, two pixel requesters and
// the frame-buffer RAM write port. The arbiter uses the slave view; the
// drawing side (or a bench) uses the master view.
interface fb_write_arbiter_if #(
    parameter int CW = 3
) ();

    logic                     clear_req;
    logic [CW-1:0]            clear_color;

    logic                     req0;
    logic [fb_pkg::X_W-1:0]   x0;
    logic [fb_pkg::Y_W-1:0]   y0;
    logic [CW-1:0]            c0;
    logic                     gnt0;

    logic                     req1;
    logic [fb_pkg::X_W-1:0]   x1;
    logic [fb_pkg::Y_W-1:0]   y1;
    logic [CW-1:0]            c1;
    logic                     gnt1;

    logic [fb_pkg::X_W-1:0]   x;
    logic [fb_pkg::Y_W-1:0]   y;
    logic [CW-1:0]            color;
    logic                     writeEn;

    logic                     busy;
    logic                     clear_done;

    modport slave (
        input  clear_req, clear_color,
        input  req0, x0, y0, c0,
        input  req1, x1, y1, c1,
        output gnt0, gnt1,
        output x, y, color, writeEn,
        output busy, clear_done
    );

    modport master (
        output clear_req, clear_color,
        output req0, x0, y0, c0,
        output req1, x1, y1, c1,
        input  gnt0, gnt1,
        input  x, y, color, writeEn,
        input  busy, clear_done
    );

endinterface

// File: rtl/fb_clear_sweeper.sv
// fb_clear_sweeper: row-major raster counter for the full-screen clear.
// start rewinds to (0,0); advance steps x and carries into y; last flags the
// final pixel (FB_W-1, FB_H-1). Counters never leave the screen range.
module fb_clear_sweeper #(
    parameter int FB_W = fb_pkg::FB_W_DEF,
    parameter int FB_H = fb_pkg::FB_H_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   advance,
    output logic [fb_pkg::X_W-1:0] x,
    output logic [fb_pkg::Y_W-1:0] y,
    output logic                   last
);
    import fb_pkg::*;

    localparam logic [X_W-1:0] X_MAX = X_W'(FB_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(FB_H - 1);

    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;

    // Raster position: rewind on start, otherwise step one pixel per advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance) begin
            if (x_q == X_MAX) begin
                x_q <= '0;
                y_q <= (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: sole writer of the frame-buffer RAM write port.
// Round-robin arbitration between two pixel requesters with a combinational
// grant and a one-cycle registered write, plus a full-screen clear sweep that
// owns the port while busy. Off-screen pixels are granted but not written.
// Build option: define FB_AUTO_CLEAR_EN to start a colour-0 clear sweep on
// the first clock after reset is released.
module fb_write_arbiter #(
    parameter int COLOR_CHANNEL_DEPTH = 1,
    parameter int FB_W                = fb_pkg::FB_W_DEF,
    parameter int FB_H                = fb_pkg::FB_H_DEF
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    fb_write_arbiter_if.slave  bus
);
    import fb_pkg::*;

    localparam int           CW    = 3 * COLOR_CHANNEL_DEPTH;
    localparam logic [X_W:0] X_LIM = (X_W + 1)'(FB_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(FB_H);

    state_t                 state_q;
    state_t                 state_d;
    logic                   rr_q;         // requester favoured when both ask
    logic [CW-1:0]          clr_color_q;
    logic                   auto_clr;
    logic                   clr_take;

    logic                   gnt0;
    logic                   gnt1;
    logic                   sweep_start;
    logic                   sweep_adv;
    logic                   sweep_last;
    logic [X_W-1:0]         sweep_x;
    logic [Y_W-1:0]         sweep_y;

    pixel_t                 wr_p0;
    logic                   vld_p0;
    logic                   done_p0;
    pixel_t                 wr_p1;
    logic                   vld_p1;
    logic                   done_p1;
    logic [COLOR_W_MAX-1:0] unused_color_hi;

    function automatic logic on_screen(input logic [X_W-1:0] px,
                                       input logic [Y_W-1:0] py);
        return ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);
    endfunction

`ifdef FB_AUTO_CLEAR_EN
    // Auto-clear request: armed by reset, consumed by the first clock after release.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            auto_clr <= 1'b1;
        end else begin
            auto_clr <= 1'b0;
        end
    end
`else
    assign auto_clr = 1'b0;
`endif

    // A clear request is only honoured from IDLE; it pre-empts both requesters.
    assign clr_take = (state_q == ST_IDLE) && (bus.clear_req || auto_clr);

    fb_clear_sweeper #(
        .FB_W (FB_W),
        .FB_H (FB_H)
    ) u_sweeper (
        .clk     (CLOCK_50),
        .rst     (reset),
        .start   (sweep_start),
        .advance (sweep_adv),
        .x       (sweep_x),
        .y       (sweep_y),
        .last    (sweep_last)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> CLEAR on an accepted clear, CLEAR -> IDLE after the last pixel.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (clr_take)   state_d = ST_CLEAR;
            ST_CLEAR: if (sweep_last) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // State outputs: grants, sweeper control and the pixel heading for the write stage.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        sweep_start = 1'b0;
        sweep_adv   = 1'b0;
        done_p0     = 1'b0;
        vld_p0      = 1'b0;
        wr_p0       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_take) begin
                    sweep_start = 1'b1;
                end else if (bus.req0 && (!bus.req1 || !rr_q)) begin
                    gnt0 = 1'b1;
                end else if (bus.req1) begin
                    gnt1 = 1'b1;
                end
                if (gnt0) begin
                    wr_p0.x     = bus.x0;
                    wr_p0.y     = bus.y0;
                    wr_p0.color = COLOR_W_MAX'(bus.c0);
                    vld_p0      = on_screen(bus.x0, bus.y0);
                end else if (gnt1) begin
                    wr_p0.x     = bus.x1;
                    wr_p0.y     = bus.y1;
                    wr_p0.color = COLOR_W_MAX'(bus.c1);
                    vld_p0      = on_screen(bus.x1, bus.y1);
                end
            end
            ST_CLEAR: begin
                sweep_adv   = 1'b1;
                vld_p0      = 1'b1;
                wr_p0.x     = sweep_x;
                wr_p0.y     = sweep_y;
                wr_p0.color = COLOR_W_MAX'(clr_color_q);
                done_p0     = sweep_last;
            end
            default: begin
                vld_p0 = 1'b0;
            end
        endcase
    end

    // Round-robin pointer: after serving one requester, favour the other.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (gnt0) begin
            rr_q <= 1'b1;
        end else if (gnt1) begin
            rr_q <= 1'b0;
        end
    end

    // Fill colour is captured when the clear is accepted; auto-clear fills with 0.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clr_color_q <= '0;
        end else if (clr_take) begin
            clr_color_q <= auto_clr ? '0 : bus.clear_color;
        end
    end

    // Write stage: registered RAM port; address/data only move on a real write.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_p1   <= '0;
            vld_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            done_p1 <= done_p0;
            if (vld_p0) begin
                wr_p1 <= wr_p0;
            end
        end
    end

    assign bus.gnt0        = gnt0;
    assign bus.gnt1        = gnt1;
    assign bus.x           = wr_p1.x;
    assign bus.y           = wr_p1.y;
    assign bus.color       = wr_p1.color[CW-1:0];
    assign bus.writeEn     = vld_p1;
    assign bus.busy        = (state_q == ST_CLEAR);
    assign bus.clear_done  = done_p1;
    assign unused_color_hi = wr_p1.color;

endmodule
